uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: accepts bytes over a valid/ready handshake and shifts them out on `tx` as 8N1 frames, LSB first. It is the transmit half of the UART controller and sits beside the receiver, driven by the same system clock. A one-entry holding register lets the next byte be queued while the current frame shifts, so frames can run back-to-back with no idle gap. Bit timing comes from an internal divider; no external baud clock is used.

## Interface
- `DIV`, default 5208: system clocks per bit (50 MHz / 9600 baud); legal range 2..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `data`  in  8  byte to transmit; sampled when `valid && ready`.
- `valid`  in  1  `data` is valid this cycle.
- `ready`  out  1  holding register empty; a byte is accepted on any edge where `valid && ready`.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is on the line or a byte is held.

## Operation
- Registers:
  - `hold[7:0]` and `hold_full` (holding register).
  - `shreg[7:0]` (shift register).
  - `bitcnt[2:0]`.
  - `divcnt[15:0]`, counts 0..DIV-1; `tick` = (`divcnt == DIV-1`).
  - `state`.
- FSM states:
  - IDLE: `tx`=1. If `hold_full`, load `shreg`←`hold`, clear `hold_full`, reset `divcnt` to 0, go to START.
  - START: `tx`=0. On `tick`, set `bitcnt`=0 and go to DATA.
  - DATA: `tx`=`shreg[0]`. On `tick`, shift right; if `bitcnt`==7 go to PARITY (when enabled) or STOP; otherwise increment `bitcnt`.
  - PARITY: `tx`=even parity of the byte. On `tick`, go to STOP.
  - STOP: `tx`=1. On `tick`, if `hold_full`, reload `shreg`, clear `hold_full`, go to START; otherwise go to IDLE.
- `divcnt` resets to 0 on every state entry, so each bit lasts exactly DIV cycles.
- Acceptance: on `valid && ready`, `hold`←`data` and `hold_full`←1. `ready` = !`hold_full` (registered, next-state based).
- Simultaneous accept and reload on the same edge: the reload takes the old `hold`, and the new byte lands in `hold`; `hold_full` stays 1.
- `busy` = (state != IDLE) || `hold_full`.
- `valid` while `ready`=0 is ignored; the byte is not latched and no error is flagged. Holding `data` stable is the upstream's job.

## Timing
- Reset values: `tx`=1, `ready`=1, `busy`=0, state IDLE, `hold_full`=0, all counters 0.
- Reset takes effect mid-frame on the next edge: `tx`=1, and the held byte is discarded.
- Latency:
  - Accept at edge k while idle → `hold_full` at k.
  - IDLE→START at edge k+1 → `tx` falls at k+1.
  - `ready` returns high at k+1.
- Frame length: 10·DIV cycles (11·DIV with parity). `tx` is registered (glitch-free).
- Back-to-back: the next start bit begins on the edge right after the last stop-bit cycle, with zero idle cycles.
- Throughput: one byte per 10·DIV cycles; at most one byte held.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted after bit 7.
  - Frame is 8E1, `tx` = XOR of the data bits (even parity), 11·DIV cycles.
- Macro undefined: the PARITY state and its logic are absent; frames are 8N1, 10·DIV cycles.

## Test plan
- Reset: hold `rst`=1 for 5 cycles with `valid`=1 → `tx`=1, `ready`=1, `busy`=0 throughout; nothing transmitted after release until a new valid.
- Single byte, DIV=4: send 0x75 → `tx` = 0,1,0,1,0,1,1,1,0,1, each level for exactly 4 cycles. Start bit begins 1 cycle after accept; `busy` drops on the edge after the stop bit.
- Back-to-back, DIV=4: send 0x75, then 0x24 while the first frame is in DATA → second frame is 0,0,0,1,0,0,1,0,0,1 starting immediately after the first stop bit. `ready` is low from the 0x24 accept until its reload.
- Backpressure: with the hold register full, present 0xFF with `valid`=1 → not accepted; line output shows only the two queued bytes.
- Reset mid-frame: assert `rst` during bit 3 of 0xA5 → `tx`=1 on the next edge, `ready`=1, and no further frame output.
- Parity build, DIV=4: send 0x75 → parity bit 1; send 0x24 → parity bit 0; frame length 44 cycles each.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter (8N1, LSB first)
//
// Accepts bytes over a valid/ready handshake into a one-entry holding
// register and shifts them out on `tx`. A byte can be queued while the
// current frame is still on the line, so frames run back-to-back with no
// idle gap. Bit timing comes from an internal divider of DIV clocks per bit.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent after data
//                      bit 7 (8E1 frame, 11*DIV cycles). When undefined the
//                      frame is 8N1 (10*DIV cycles) and no parity logic exists.
//
// Parameters:
//   DIV    system clocks per bit, legal range 2..65535 (default 5208).
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   data   in   [7:0] byte to transmit, sampled when valid && ready
//   valid  in   data is valid this cycle
//   ready  out  holding register empty (registered)
//   tx     out  serial line, idles high (registered, glitch-free)
//   busy   out  frame on the line or byte held (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  // Reject illegal divider values at elaboration time.
  if (DIV < 2 || DIV > 65535) begin : g_div_check
    $error("uart_tx: DIV must be in 2..65535");
  end

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  logic [7:0]  hold_q,      hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shreg_q,     shreg_d;
  logic [2:0]  bitcnt_q,    bitcnt_d;
  logic [15:0] divcnt_q,    divcnt_d;
  logic        tx_q,        tx_d;
  logic        ready_q,     ready_d;
  logic        busy_q,      busy_d;
`ifdef UART_TX_PARITY_EN
  // Parity of the byte being shifted, captured at load time because the
  // shift register no longer holds the full byte by the time it is sent.
  logic        parity_q,    parity_d;
`endif

  logic tick;
  logic accept;
  logic load;

  // End of the current bit period.
  assign tick   = (divcnt_q == DIV_M1);
  // ready_q always mirrors !hold_full_q, so an accept never lands on a full
  // holding register.
  assign accept = valid && ready_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          // A queued byte starts on the very next edge: no idle gap.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reload takes the old holding byte and frees the register.
    if (load) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    // Accept is evaluated after reload so a same-edge accept keeps the
    // register full with the new byte.
    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end
  end

  // Bit-period divider. Every state transition out of a shifting state
  // happens on a tick, which already wraps the counter, and IDLE pins it to
  // zero, so each state entry starts a fresh DIV-cycle bit.
  always_comb begin
    if (state_q == S_IDLE || tick) begin
      divcnt_d = 16'd0;
    end else begin
      divcnt_d = divcnt_q + 16'd1;
    end
  end

  // Registered outputs are computed from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    ready_d = !hold_full_d;
    busy_d  = (state_d != S_IDLE) || hold_full_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the data registers (hold, shreg) are reset along with the control
  // state; they are small, and this keeps tx free of X after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shreg_q     <= 8'd0;
      bitcnt_q    <= 3'd0;
      divcnt_q    <= 16'd0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      divcnt_q    <= divcnt_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// The driver pushes each accepted byte, with the cycle its start bit is due,
// into a scoreboard queue. A monitor watches tx on the falling clock edge,
// pops the expected byte when a start bit appears and compares every bit
// period against the frame the byte should produce.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  uart_tx #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  exp_t sb_q[$];
  int   last_end = 0;   // cycle at which the last scheduled frame ends

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Line level for bit i of the frame carrying byte b: start, 8 data bits
  // LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0)           return 1'b0;
    else if (i <= 8)      return b[i-1];
    else if (i == NB - 1) return 1'b1;
    else                  return ^b;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic mon_active = 1'b0;
  logic bogus      = 1'b0;
  exp_t cur;
  int   bit_idx   = 0;
  int   samp      = 0;
  int   match_cnt = 0;
  int   frame_no  = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_frame", "start bit seen with no byte queued");
          bogus = 1'b1;
        end else begin
          cur   = sb_q.pop_front();
          bogus = 1'b0;
          check($sformatf("frame%0d_start_cycle", frame_no), cyc, cur.start);
        end
        mon_active = 1'b1;
        bit_idx    = 0;
        samp       = 0;
        match_cnt  = 0;
      end
      if (mon_active) begin
        if (!bogus && tx === frame_bit(cur.b, bit_idx)) match_cnt++;
        samp++;
        if (samp == DIV) begin
          if (!bogus)
            check($sformatf("frame%0d_byte%02h_bit%0d_cycles_ok", frame_no, cur.b, bit_idx),
                  match_cnt, DIV);
          bit_idx++;
          samp      = 0;
          match_cnt = 0;
          if (bit_idx == NB) begin
            mon_active = 1'b0;
            frame_no++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer byte b; returns the accept edge and the predicted start-bit cycle.
  task automatic send(input logic [7:0] b, output int acc, output int st);
    int tries = 0;
    data  = b;
    valid = 1'b1;
    while (ready !== 1'b1 && tries < 3 * FRAME) begin
      tick_n(1);
      tries++;
    end
    if (ready !== 1'b1) begin
      fail_now("send_timeout", "ready never returned high");
      valid = 1'b0;
      acc   = -1;
      st    = -1;
      return;
    end
    acc = cyc + 1;
    tick_n(1);
    valid = 1'b0;
    // Start bit follows the accept by one cycle, or waits for the previous
    // frame to end, whichever is later.
    st = (acc + 1 > last_end) ? acc + 1 : last_end;
    last_end = st + FRAME;
    sb_q.push_back('{b: b, start: st});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || mon_active || sb_q.size() != 0) && n < 30 * FRAME) begin
      tick_n(1);
      n++;
    end
    check(name, (busy === 1'b0 && !mon_active && sb_q.size() == 0), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int acc, st, acc2, st2, n;

    // Reset held with valid asserted: outputs stay at idle values.
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick_n(1);
      check($sformatf("reset_tx_%0d", i), tx, 1);
      check($sformatf("reset_ready_%0d", i), ready, 1);
      check($sformatf("reset_busy_%0d", i), busy, 0);
    end
    rst   = 1'b0;
    valid = 1'b0;
    tick_n(3 * DIV);
    check("post_reset_busy", busy, 0);
    check("post_reset_tx", tx, 1);

    // Single byte 0x75.
    send(8'h75, acc, st);
    check("single_ready_low_after_accept", ready, 0);
    check("single_busy_after_accept", busy, 1);
    tick_n(1);
    check("single_ready_back_high", ready, 1);
    check("single_start_bit_low", tx, 0);
    tick_n(FRAME - 1);
    check("single_busy_in_last_stop_cycle", busy, 1);
    check("single_tx_stop_level", tx, 1);
    tick_n(1);
    check("single_busy_drops_after_stop", busy, 0);
    wait_idle("single_idle");

    // Back-to-back 0x75 then 0x24, with 0xFF offered while the register is full.
    send(8'h75, acc, st);
    tick_n(3 * DIV);
    send(8'h24, acc2, st2);
    check("b2b_ready_low_while_held", ready, 0);
    data  = 8'hFF;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("backpressure_ready_low_%0d", i), ready, 0);
      check($sformatf("backpressure_busy_%0d", i), busy, 1);
      tick_n(1);
    end
    valid = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 2 * FRAME) begin
      tick_n(1);
      n++;
    end
    check("b2b_ready_rises_at_reload", cyc, st + FRAME);
    wait_idle("b2b_idle");

    // Reset in the middle of data bit 3 of 0xA5.
    send(8'hA5, acc, st);
    tick_n(st + 4 * DIV + 1 - cyc);
    rst = 1'b1;
    tick_n(1);
    check("midreset_tx_high", tx, 1);
    check("midreset_ready_high", ready, 1);
    check("midreset_busy_low", busy, 0);
    rst = 1'b0;
    sb_q.delete();
    last_end = 0;
    tick_n(2 * FRAME);
    check("midreset_tx_stays_idle", tx, 1);
    check("midreset_busy_stays_low", busy, 0);

    // Random bytes with random gaps, including offers while a frame is busy.
    for (int i = 0; i < 24; i++) begin
      tick_n($urandom_range(0, FRAME + DIV));
      send(8'($urandom), acc, st);
    end
    wait_idle("random_idle");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
